timer_scheduler: RTL and testbench
==================================

Name: timer_scheduler

Overview:
- Shares one `timer` instance between N_REQ requesters, each asking for a delay of `req_len` cycles.
- Round-robin arbitration picks the next requester; the block then sequences the timer (clear, load/start, pause/resume, done) and returns a per-requester completion pulse.
- Sits between client FSMs and the single `timer`, and owns every `timer` control pin.

Parameters:
- N_REQ, 4, number of requesters (≥2).
- DATA_WIDTH, 8, width of a delay value; matches the `timer` DATA_WIDTH.
- IDX_W, $clog2(N_REQ), localparam, width of requester index.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester request, level; held until its gnt bit pulses.
- req_len  in  N_REQ*DATA_WIDTH  delay for requester i in bits [i*DATA_WIDTH +: DATA_WIDTH]; sampled on grant.
- cancel  in  N_REQ  per-requester abort, level; acts only for the current owner.
- pause  in  1  global pause, level.
- gnt  out  N_REQ  one-hot, one-cycle pulse when a request is accepted.
- done_out  out  N_REQ  one-hot, one-cycle pulse when the owner's delay expires.
- busy  out  1  high in any state other than IDLE.
- owner  out  IDX_W  index of the current/last granted requester.
- tmr_rst  out  1  drives the `timer` rst (active-high, synchronous in `timer`).
- tmr_start  out  1  drives the `timer` start: loads on first start, resumes when paused.
- tmr_stop  out  1  drives the `timer` stop (pause).
- tmr_data  out  DATA_WIDTH  drives the `timer` data_in.
- tmr_done  in  1  the `timer` done, level, sticky until tmr_rst.

Behaviour:
- All outputs registered. Reset values: state = IDLE, tmr_rst = 1, all other outputs 0, rr pointer last_q = N_REQ-1 (so requester 0 wins first), owner = 0, len_q = 0.
- Async reset mid-job abandons the job with no done_out. tmr_rst stays 1 until the first clock after release, then drops in IDLE, which guarantees a cleared `timer`.
- States: IDLE, LOAD, RUN, PAUSED, FINISH, ABORT.
- IDLE: tmr_rst = 0. If any req bit is set:
  - Select the first set bit searching cyclically from last_q+1.
  - Latch owner, len_q = req_len slice, last_q = selected index.
  - If the slice ≠ 0, go to LOAD; if it is 0, go to FINISH without touching the `timer`.
- LOAD: gnt[owner] = 1, tmr_start = 1, tmr_data = len_q (held at len_q until IDLE). Go to RUN.
- Zero-length job: gnt[owner] and done_out[owner] pulse together in FINISH.
- RUN priority, one event per cycle:
  - cancel[owner]: go to ABORT.
  - else tmr_done: go to FINISH.
  - else pause: tmr_stop = 1 for one cycle, go to PAUSED.
  - else stay in RUN.
- PAUSED:
  - cancel[owner]: go to ABORT.
  - else !pause: tmr_start = 1 for one cycle, go to RUN.
  - else stay.
  - tmr_done is ignored in PAUSED (the timer does not expire while stopped).
- FINISH: done_out[owner] = 1, tmr_rst = 1 (one cycle). Go to IDLE.
- ABORT: tmr_rst = 1, no done_out. Go to IDLE.
- Latency:
  - req high in IDLE at cycle T → gnt/tmr_start at T+1.
  - tmr_done first high at D in RUN → done_out at D+1, back in IDLE at D+2.
  - Back-to-back jobs therefore have 1 IDLE cycle between FINISH and the next LOAD.
- Cancel on a non-owner bit, or while in IDLE, has no effect. req bits of the owner seen after gnt are treated as a new request in the next IDLE.
- tmr_start, tmr_stop and tmr_rst are never asserted in the same cycle.

Decomposition:
- Package `timer_pkg`: enum `sched_state_e` (IDLE, LOAD, RUN, PAUSED, FINISH, ABORT) and a `DATA_WIDTH_DEF` = 8 constant.
- Sub-module `rr_arbiter` (params N_REQ; inputs req, last_q; outputs valid, idx), purely combinational priority rotate.
- FSM, len_q and output registers stay in `timer_scheduler`.

Test Plan:
- Reset release, req = 0001, len0 = 10, `timer` model attached:
  - gnt[0] and tmr_start (tmr_data = 10) 1 cycle after IDLE sample.
  - done_out[0] 1 cycle after tmr_done.
  - tmr_rst pulse in the same cycle as done_out; busy low after.
- req = 1111, all len = 3, held continuously → grants in order 0,1,2,3,0; each gnt exactly one cycle; no overlap of busy jobs.
- req[2] with len = 15, pause high for 4 cycles after 5 RUN cycles:
  - Exactly one tmr_stop, then one tmr_start on release.
  - done_out[2] when the `timer` reaches 15 counted cycles.
- req[1] with len = 0 → gnt[1] and done_out[1] in the same cycle; tmr_start never asserted.
- req[3] with len = 16, cancel[3] after 8 RUN cycles → tmr_rst one cycle, no done_out, IDLE next. Same test with cancel[0] instead → ignored.
- Assert rst low for 2 cycles mid-RUN (len = 16) → all outputs 0 immediately except tmr_rst = 1. After release: IDLE, tmr_rst drops, next grant goes to requester 0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and defaults for the timer scheduler slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package timer_pkg;

    // Default delay width, matching the shared timer's data_in width.
    localparam int DATA_WIDTH_DEF = 8;

    // Scheduler sequencing states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RUN    = 3'd2,
        PAUSED = 3'd3,
        FINISH = 3'd4,
        ABORT  = 3'd5
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set req bit searching cyclically from last_q+1.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to consume the pick.
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_q,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Walk from the farthest candidate to the nearest so the nearest set bit wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            if (req[(int'(last_q) + i) % N_REQ]) begin
                valid = 1'b1;
                idx   = IDX_W'((int'(last_q) + i) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/timer_scheduler.sv
// Shares one timer between N_REQ requesters: round-robin grant, sequences clear/load/pause/resume, returns done pulse.
// Latency: req in IDLE -> gnt/tmr_start next cycle; tmr_done in RUN -> done_out next cycle, IDLE the cycle after.
// Backpressure: req is level and held until its gnt pulse; gnt/done_out are single-cycle pulses with no ready.
module timer_scheduler
    import timer_pkg::*;
#(
    parameter  int N_REQ      = 4,
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    localparam int IDX_W      = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_len,
    input  logic [N_REQ-1:0]            cancel,
    input  logic                        pause,
    output logic [N_REQ-1:0]            gnt,
    output logic [N_REQ-1:0]            done_out,
    output logic                        busy,
    output logic [IDX_W-1:0]            owner,
    output logic                        tmr_rst,
    output logic                        tmr_start,
    output logic                        tmr_stop,
    output logic [DATA_WIDTH-1:0]       tmr_data,
    input  logic                        tmr_done
);

    sched_state_e          state_q, state_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic [IDX_W-1:0]      last_q, last_d;
    logic [DATA_WIDTH-1:0] len_q, len_d;

    logic [N_REQ-1:0]      gnt_q, gnt_d;
    logic [N_REQ-1:0]      done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  tmr_rst_q, tmr_rst_d;
    logic                  tmr_start_q, tmr_start_d;
    logic                  tmr_stop_q, tmr_stop_d;
    logic [DATA_WIDTH-1:0] tmr_data_q, tmr_data_d;

    logic                  arb_vld;
    logic [IDX_W-1:0]      arb_idx;
    logic [DATA_WIDTH-1:0] sel_len;
    logic                  start_job;
    logic [N_REQ-1:0]      owner_onehot;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req    (req),
        .last_q (last_q),
        .valid  (arb_vld),
        .idx    (arb_idx)
    );

    assign sel_len = req_len[int'(arb_idx) * DATA_WIDTH +: DATA_WIDTH];

    // Next-state sequencing: one event per cycle, cancel beats done beats pause.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        len_d     = len_q;
        start_job = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    start_job = 1'b1;
                    owner_d   = arb_idx;
                    last_d    = arb_idx;
                    len_d     = sel_len;
                    // Zero-length jobs complete without ever loading the timer.
                    state_d   = (sel_len != '0) ? LOAD : FINISH;
                end
            end
            LOAD: begin
                state_d = RUN;
            end
            RUN: begin
                if (cancel[owner_q]) begin
                    state_d = ABORT;
                end else if (tmr_done) begin
                    state_d = FINISH;
                end else if (pause) begin
                    state_d = PAUSED;
                end
            end
            PAUSED: begin
                // The timer cannot expire while stopped, so tmr_done is not looked at here.
                if (cancel[owner_q]) begin
                    state_d = ABORT;
                end else if (!pause) begin
                    state_d = RUN;
                end
            end
            FINISH, ABORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output next values are a function of the transition so every output is a plain flop.
    always_comb begin
        owner_onehot = N_REQ'(1) << owner_d;
        gnt_d        = start_job ? owner_onehot : '0;
        done_d       = (state_d == FINISH) ? owner_onehot : '0;
        busy_d       = (state_d != IDLE);
        tmr_rst_d    = (state_d == FINISH) || (state_d == ABORT);
        tmr_start_d  = (state_d == LOAD) || ((state_q == PAUSED) && (state_d == RUN));
        tmr_stop_d   = (state_q == RUN) && (state_d == PAUSED);
        // Data stays at the job length for the whole job so a resume sees a stable value.
        tmr_data_d   = (state_d == IDLE) ? '0 : len_d;
    end

    // State and output registers; reset holds the timer in clear and abandons any job.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            last_q      <= IDX_W'(N_REQ - 1);
            len_q       <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            busy_q      <= 1'b0;
            tmr_rst_q   <= 1'b1;
            tmr_start_q <= 1'b0;
            tmr_stop_q  <= 1'b0;
            tmr_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            len_q       <= len_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            tmr_rst_q   <= tmr_rst_d;
            tmr_start_q <= tmr_start_d;
            tmr_stop_q  <= tmr_stop_d;
            tmr_data_q  <= tmr_data_d;
        end
    end

    assign gnt       = gnt_q;
    assign done_out  = done_q;
    assign busy      = busy_q;
    assign owner     = owner_q;
    assign tmr_rst   = tmr_rst_q;
    assign tmr_start = tmr_start_q;
    assign tmr_stop  = tmr_stop_q;
    assign tmr_data  = tmr_data_q;

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler with a behavioural timer attached.
// Latency: n/a.
// Backpressure: n/a.
module tb_timer_scheduler;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_len;
    logic [N-1:0]    cancel;
    logic            pause;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done_out;
    logic            busy;
    logic [1:0]      owner;
    logic            tmr_rst;
    logic            tmr_start;
    logic            tmr_stop;
    logic [DW-1:0]   tmr_data;
    logic            tmr_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    timer_scheduler #(.N_REQ(N), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_len   (req_len),
        .cancel    (cancel),
        .pause     (pause),
        .gnt       (gnt),
        .done_out  (done_out),
        .busy      (busy),
        .owner     (owner),
        .tmr_rst   (tmr_rst),
        .tmr_start (tmr_start),
        .tmr_stop  (tmr_stop),
        .tmr_data  (tmr_data),
        .tmr_done  (tmr_done)
    );

    // Behavioural timer: sync clear, load on first start, resume on later starts, stop pauses.
    logic [DW-1:0] t_cnt, t_tgt;
    logic          t_run, t_loaded, t_done;
    assign tmr_done = t_done;

    always @(posedge clk) begin
        if (tmr_rst) begin
            t_cnt <= '0; t_tgt <= '0; t_run <= 1'b0; t_loaded <= 1'b0; t_done <= 1'b0;
        end else if (tmr_start) begin
            if (!t_loaded) begin
                t_loaded <= 1'b1; t_tgt <= tmr_data; t_cnt <= '0;
            end
            t_run <= 1'b1;
        end else if (tmr_stop) begin
            t_run <= 1'b0;
        end else if (t_run && !t_done) begin
            t_cnt <= DW'(t_cnt + 1'b1);
            if (DW'(t_cnt + 1'b1) == t_tgt) t_done <= 1'b1;
        end
    end

    // Timer controls must never overlap.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            checks++;
            if ($countones({tmr_rst, tmr_start, tmr_stop}) > 1) begin
                failures++;
                $display("FAIL ctrl_exclusive: rst/start/stop=%b%b%b, at most one allowed", tmr_rst, tmr_start, tmr_stop);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req = '0; cancel = '0; pause = 1'b0; req_len = '0;
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
    endtask

    task automatic wait_idle(input int bound);
        int c;
        c = 0;
        while (busy !== 1'b0 && c < bound) begin
            tick(); c++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, expected 0", busy, bound);
        end
    endtask

    task automatic test_reset();
        req = '0; cancel = '0; pause = 1'b0; req_len = '0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({gnt, done_out, busy, owner, tmr_start, tmr_stop, tmr_data} !== '0 || tmr_rst !== 1'b1) begin
            failures++;
            $display("FAIL reset_values: gnt=%b done=%b busy=%b owner=%0d start=%b stop=%b data=%0d rst=%b, expected zeros with tmr_rst=1",
                     gnt, done_out, busy, owner, tmr_start, tmr_stop, tmr_data, tmr_rst);
        end
        tick(); tick();
        rst = 1'b1;
        tick();
        checks++;
        if (tmr_rst !== 1'b0 || busy !== 1'b0 || gnt !== '0) begin
            failures++;
            $display("FAIL reset_release: tmr_rst=%b busy=%b gnt=%b, expected 0 0 0000", tmr_rst, busy, gnt);
        end
    endtask

    task automatic test_single();
        int  c;
        bit  seen;
        logic prev;
        req_len[0*DW +: DW] = 8'd10;
        req = 4'b0001;
        tick();
        checks++;
        if (gnt !== 4'b0001 || tmr_start !== 1'b1 || tmr_data !== 8'd10 || busy !== 1'b1 || owner !== 2'd0) begin
            failures++;
            $display("FAIL single_grant: gnt=%b start=%b data=%0d busy=%b owner=%0d, expected 0001 1 10 1 0",
                     gnt, tmr_start, tmr_data, busy, owner);
        end
        req = '0;
        seen = 1'b0; prev = 1'b0; c = 0;
        while (!seen && c < 40) begin
            prev = tmr_done;
            tick(); c++;
            if (done_out !== '0) seen = 1'b1;
        end
        checks++;
        if (!seen || c != 12 || done_out !== 4'b0001 || tmr_rst !== 1'b1 || prev !== 1'b1) begin
            failures++;
            $display("FAIL single_done: seen=%b cycle=%0d done=%b tmr_rst=%b prev_tmr_done=%b, expected 1 12 0001 1 1",
                     seen, c, done_out, tmr_rst, prev);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || tmr_rst !== 1'b0 || done_out !== '0) begin
            failures++;
            $display("FAIL single_idle: busy=%b tmr_rst=%b done=%b, expected 0 0 0000", busy, tmr_rst, done_out);
        end
    endtask

    task automatic test_round_robin();
        int           exp_idx [5] = '{0, 1, 2, 3, 0};
        int           g_cyc [5];
        logic [N-1:0] g_val [5];
        logic [N-1:0] prev_gnt;
        int           ng, c;
        apply_reset();
        for (int i = 0; i < N; i++) req_len[i*DW +: DW] = 8'd3;
        req = 4'b1111;
        ng = 0; c = 0; prev_gnt = '0;
        while (ng < 5 && c < 80) begin
            tick(); c++;
            if (gnt !== '0) begin
                checks++;
                if (prev_gnt !== '0) begin
                    failures++;
                    $display("FAIL rr_pulse_width: gnt=%b also high previous cycle (%b), expected single-cycle", gnt, prev_gnt);
                end
                g_val[ng] = gnt; g_cyc[ng] = c; ng++;
            end
            prev_gnt = gnt;
        end
        req = '0;
        checks++;
        if (ng != 5) begin
            failures++;
            $display("FAIL rr_count: got %0d grants, expected 5", ng);
        end
        for (int i = 0; i < ng; i++) begin
            checks++;
            if (g_val[i] !== (4'b0001 << exp_idx[i])) begin
                failures++;
                $display("FAIL rr_order[%0d]: gnt=%b, expected requester %0d", i, g_val[i], exp_idx[i]);
            end
            if (i > 0) begin
                checks++;
                if (g_cyc[i] - g_cyc[i-1] != 7) begin
                    failures++;
                    $display("FAIL rr_spacing[%0d]: %0d cycles between grants, expected 7", i, g_cyc[i] - g_cyc[i-1]);
                end
            end
        end
        wait_idle(20);
    endtask

    task automatic test_pause();
        int  c, stops, starts, stop_cyc, start_cyc;
        bit  seen;
        req_len[2*DW +: DW] = 8'd15;
        req = 4'b0100;
        tick();
        checks++;
        if (gnt !== 4'b0100 || tmr_data !== 8'd15) begin
            failures++;
            $display("FAIL pause_grant: gnt=%b data=%0d, expected 0100 15", gnt, tmr_data);
        end
        req = '0;
        c = 0; seen = 1'b0; stops = 0; starts = 0; stop_cyc = -1; start_cyc = -1;
        while (!seen && c < 60) begin
            tick(); c++;
            if (tmr_stop === 1'b1)  begin stops++;  stop_cyc = c;  end
            if (tmr_start === 1'b1) begin starts++; start_cyc = c; end
            if (done_out !== '0) seen = 1'b1;
            if (c == 5) pause = 1'b1;
            if (c == 9) pause = 1'b0;
        end
        pause = 1'b0;
        checks++;
        if (stops != 1 || stop_cyc != 6 || starts != 1 || start_cyc != 10) begin
            failures++;
            $display("FAIL pause_ctrl: stops=%0d@%0d starts=%0d@%0d, expected 1@6 1@10", stops, stop_cyc, starts, start_cyc);
        end
        checks++;
        if (!seen || c != 22 || done_out !== 4'b0100) begin
            failures++;
            $display("FAIL pause_done: seen=%b cycle=%0d done=%b, expected 1 22 0100", seen, c, done_out);
        end
        wait_idle(10);
    endtask

    task automatic test_zero_len();
        req_len[1*DW +: DW] = 8'd0;
        req = 4'b0010;
        tick();
        checks++;
        if (gnt !== 4'b0010 || done_out !== 4'b0010 || tmr_start !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL zero_len: gnt=%b done=%b start=%b busy=%b, expected 0010 0010 0 1", gnt, done_out, tmr_start, busy);
        end
        req = '0;
        tick();
        checks++;
        if (busy !== 1'b0 || tmr_start !== 1'b0 || done_out !== '0) begin
            failures++;
            $display("FAIL zero_len_idle: busy=%b start=%b done=%b, expected 0 0 0000", busy, tmr_start, done_out);
        end
    endtask

    task automatic test_cancel();
        int extra_done;
        req_len[3*DW +: DW] = 8'd16;
        req = 4'b1000;
        tick();
        checks++;
        if (gnt !== 4'b1000) begin
            failures++;
            $display("FAIL cancel_grant: gnt=%b, expected 1000", gnt);
        end
        req = '0;
        repeat (8) tick();
        cancel = 4'b1000;
        tick();
        checks++;
        if (tmr_rst !== 1'b1 || done_out !== '0 || busy !== 1'b1 || tmr_start !== 1'b0) begin
            failures++;
            $display("FAIL cancel_abort: tmr_rst=%b done=%b busy=%b start=%b, expected 1 0000 1 0", tmr_rst, done_out, busy, tmr_start);
        end
        cancel = '0;
        tick();
        checks++;
        if (busy !== 1'b0 || tmr_rst !== 1'b0) begin
            failures++;
            $display("FAIL cancel_idle: busy=%b tmr_rst=%b, expected 0 0", busy, tmr_rst);
        end
        extra_done = 0;
        repeat (12) begin
            tick();
            if (done_out !== '0) extra_done++;
        end
        checks++;
        if (extra_done != 0) begin
            failures++;
            $display("FAIL cancel_no_done: %0d done pulses after abort, expected 0", extra_done);
        end
    endtask

    task automatic test_cancel_other();
        int  c;
        bit  seen;
        req_len[3*DW +: DW] = 8'd16;
        req = 4'b1000;
        tick();
        req = '0;
        repeat (8) tick();
        cancel = 4'b0001;
        tick();
        checks++;
        if (tmr_rst !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL cancel_other_ignored: tmr_rst=%b busy=%b, expected 0 1", tmr_rst, busy);
        end
        c = 9; seen = 1'b0;
        while (!seen && c < 60) begin
            tick(); c++;
            if (done_out !== '0) seen = 1'b1;
        end
        cancel = '0;
        checks++;
        if (!seen || c != 18 || done_out !== 4'b1000) begin
            failures++;
            $display("FAIL cancel_other_done: seen=%b cycle=%0d done=%b, expected 1 18 1000", seen, c, done_out);
        end
        wait_idle(10);
    endtask

    task automatic test_async_reset();
        req_len[2*DW +: DW] = 8'd16;
        req = 4'b0100;
        tick();
        req = '0;
        repeat (4) tick();
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({gnt, done_out, busy, owner, tmr_start, tmr_stop, tmr_data} !== '0 || tmr_rst !== 1'b1) begin
            failures++;
            $display("FAIL async_reset: gnt=%b done=%b busy=%b owner=%0d start=%b stop=%b data=%0d rst=%b, expected zeros with tmr_rst=1",
                     gnt, done_out, busy, owner, tmr_start, tmr_stop, tmr_data, tmr_rst);
        end
        tick(); tick();
        rst = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || tmr_rst !== 1'b0 || done_out !== '0) begin
            failures++;
            $display("FAIL async_release: busy=%b tmr_rst=%b done=%b, expected 0 0 0000", busy, tmr_rst, done_out);
        end
        for (int i = 0; i < N; i++) req_len[i*DW +: DW] = 8'd5;
        req = 4'b1111;
        tick();
        checks++;
        if (gnt !== 4'b0001 || owner !== 2'd0) begin
            failures++;
            $display("FAIL async_next_grant: gnt=%b owner=%0d, expected 0001 0", gnt, owner);
        end
        req = '0;
        wait_idle(20);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_pause();
        test_zero_len();
        test_cancel();
        test_cancel_other();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
